// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU opcode encodings, FSM states and default latencies
// Imported by the MDU, the control decoder and the stall unit so all agree on
// the opcode numbering.
package mdu_pkg;

  // MDU opcodes (4-bit field carried down the pipeline from decode)
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Default busy latencies
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Busy counter width; latencies up to 255 cycles
  localparam int CNT_W = 8;

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - E-stage multiply/divide unit holding HI/LO with modelled latency
// Ports:
//   clk       pipeline clock
//   reset     synchronous active-high reset, clears all state
//   start     E-stage instruction is a valid MDU op this cycle
//   op        MDU opcode (mdu_pkg encodings)
//   SrcA      forwarded rs value
//   SrcB      forwarded rt value
//   busy      multi-cycle operation in flight (watched by the stall unit)
//   HI, LO    architectural HI/LO registers
//   MDUresult HI for MFHI, LO for MFLO, else 0 (combinational)
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUresult
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_next_q, hi_next_d;
  logic [31:0]      lo_next_q, lo_next_d;

  // Multiply: sign-extending both operands to 64 bits makes the low 64 bits
  // of an unsigned multiply equal the signed product.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
  assign prod_u = {32'd0, SrcA} * {32'd0, SrcB};

  // Divide: the divisor is forced to 1 on divide-by-zero so the operators
  // never see zero; the result is discarded in that case anyway.
  logic        den_nz;
  logic [31:0] den_u, quo_u, rem_u;
  logic [31:0] mag_a, mag_b, den_s, quo_mag, rem_mag, quo_s, rem_s;

  assign den_nz  = (SrcB != 32'd0);
  assign den_u   = den_nz ? SrcB : 32'd1;
  assign quo_u   = SrcA / den_u;
  assign rem_u   = SrcA % den_u;

  // Signed divide on magnitudes; quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 through two's-complement wrap.
  assign mag_a   = SrcA[31] ? (32'd0 - SrcA) : SrcA;
  assign mag_b   = SrcB[31] ? (32'd0 - SrcB) : SrcB;
  assign den_s   = den_nz ? mag_b : 32'd1;
  assign quo_mag = mag_a / den_s;
  assign rem_mag = mag_a % den_s;
  assign quo_s   = (SrcA[31] ^ SrcB[31]) ? (32'd0 - quo_mag) : quo_mag;
  assign rem_s   = SrcA[31] ? (32'd0 - rem_mag) : rem_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_next_d = hi_next_q;
    lo_next_d = lo_next_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              {hi_next_d, lo_next_d} = prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            OP_MULTU: begin
              {hi_next_d, lo_next_d} = prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            OP_DIV: begin
              // Divide-by-zero stages the current HI/LO so the commit is a no-op
              hi_next_d = den_nz ? rem_s : hi_q;
              lo_next_d = den_nz ? quo_s : lo_q;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = ST_RUN;
            end
            OP_DIVU: begin
              hi_next_d = den_nz ? rem_u : hi_q;
              lo_next_d = den_nz ? quo_u : lo_q;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = SrcA;
            OP_MTLO: lo_d = SrcA;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Starts are ignored here; the stall unit keeps them from arriving
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_next_q;
          lo_d    = lo_next_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_next_q <= '0;
      lo_next_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_next_q <= hi_next_d;
      lo_next_q <= lo_next_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    MDUresult = 32'd0;
    case (op)
      OP_MFHI: MDUresult = hi_q;
      OP_MFLO: MDUresult = lo_q;
      default: MDUresult = 32'd0;
    endcase
  end

endmodule
